im_loader: RTL and testbench

- Writer-side counterpart to the CPU's 1024-word instruction memory, which the fetch stage only reads.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver or debug port.
- Assembles big-endian 32-bit instruction words and drives the instruction memory's write port at consecutive word addresses.
- Holds the CPU in halt until the image is complete, so the board can be reprogrammed without resynthesis.

---
 rtl/im_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_im_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// Byte-stream loader for the 1024-word instruction memory; holds the CPU in halt until the image is complete.
// Optional trailing XOR checksum byte enabled by defining IM_LOADER_CHECKSUM_EN.
module im_loader #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          im_we,
  output logic [AW-1:0] im_waddr,
  output logic [31:0]   im_wdata,
  output logic          cpu_halt,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW:0]   words_loaded
);

  localparam int unsigned CW  = 16;
  localparam int unsigned WW  = 32;
  localparam int unsigned BW  = 8;
  localparam int unsigned WLW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef IM_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [WW-1:0]  word_q, word_d;
  logic [1:0]     byte_idx_q, byte_idx_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           rx_ready_q, rx_ready_d;
  logic           im_we_q, im_we_d;
  logic [AW-1:0]  im_waddr_q, im_waddr_d;
  logic [WW-1:0]  im_wdata_q, im_wdata_d;
  logic           cpu_halt_q, cpu_halt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           error_q, error_d;
  logic [WLW-1:0] words_loaded_q, words_loaded_d;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [BW-1:0]  chk_q, chk_d;
`endif

  logic           hs;
  logic [CW-1:0]  len_n;
  logic           last_word;
  logic [WW-1:0]  word_n;

  assign hs        = rx_valid && rx_ready_q;
  assign len_n     = {count_q[CW-1:BW], rx_data};
  assign last_word = (CW'(addr_q) + CW'(1)) == count_q;
  assign word_n    = {word_q[WW-BW-1:0], rx_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      word_q         <= '0;
      byte_idx_q     <= '0;
      addr_q         <= '0;
      rx_ready_q     <= 1'b0;
      im_we_q        <= 1'b0;
      im_waddr_q     <= '0;
      im_wdata_q     <= '0;
      cpu_halt_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      words_loaded_q <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      chk_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      word_q         <= word_d;
      byte_idx_q     <= byte_idx_d;
      addr_q         <= addr_d;
      rx_ready_q     <= rx_ready_d;
      im_we_q        <= im_we_d;
      im_waddr_q     <= im_waddr_d;
      im_wdata_q     <= im_wdata_d;
      cpu_halt_q     <= cpu_halt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      words_loaded_q <= words_loaded_d;
`ifdef IM_LOADER_CHECKSUM_EN
      chk_q          <= chk_d;
`endif
    end
  end

  // Next-state and registered-output logic; rx_ready follows the state being entered.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    word_d         = word_q;
    byte_idx_d     = byte_idx_q;
    addr_d         = addr_q;
    rx_ready_d     = 1'b0;
    im_we_d        = 1'b0;
    im_waddr_d     = im_waddr_q;
    im_wdata_d     = im_wdata_q;
    cpu_halt_d     = cpu_halt_q;
    busy_d         = busy_q;
    done_d         = done_q;
    error_d        = error_q;
    words_loaded_d = words_loaded_q;
`ifdef IM_LOADER_CHECKSUM_EN
    chk_d          = chk_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (load_start) begin
          state_d        = S_LEN_HI;
          done_d         = 1'b0;
          error_d        = 1'b0;
          words_loaded_d = '0;
          busy_d         = 1'b1;
          cpu_halt_d     = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
          chk_d          = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (hs) begin
          count_d = {rx_data, count_q[BW-1:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (hs) begin
          count_d = len_n;
          // Reject empty images and images larger than the memory, so the address can never wrap.
          if ((len_n == '0) || (len_n > CW'(DEPTH))) begin
            state_d = S_ERROR;
            busy_d  = 1'b0;
            error_d = 1'b1;
          end else begin
            state_d    = S_DATA;
            byte_idx_d = '0;
            addr_d     = '0;
          end
        end
      end
      S_DATA: begin
        if (hs) begin
          word_d     = word_n;
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
          chk_d      = chk_q ^ rx_data;
`endif
          if (byte_idx_q == 2'd3) begin
            state_d    = S_WRITE;
            im_we_d    = 1'b1;
            im_waddr_d = addr_q;
            im_wdata_d = word_n;
          end
        end
      end
      S_WRITE: begin
        words_loaded_d = words_loaded_q + WLW'(1);
        if (last_word) begin
`ifdef IM_LOADER_CHECKSUM_EN
          state_d    = S_CHK;
`else
          state_d    = S_DONE;
          busy_d     = 1'b0;
          cpu_halt_d = 1'b0;
          done_d     = 1'b1;
`endif
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = S_DATA;
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (hs) begin
          busy_d = 1'b0;
          if (rx_data == chk_q) begin
            state_d    = S_DONE;
            cpu_halt_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_LEN_HI, S_LEN_LO, S_DATA: rx_ready_d = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
      S_CHK:                      rx_ready_d = 1'b1;
`endif
      default:                    rx_ready_d = 1'b0;
    endcase
  end

  assign rx_ready     = rx_ready_q;
  assign im_we        = im_we_q;
  assign im_waddr     = im_waddr_q;
  assign im_wdata     = im_wdata_q;
  assign cpu_halt     = cpu_halt_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected memory writes are queued by the stimulus and popped by a write monitor.
module tb_im_loader;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;
`ifdef IM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          im_we;
  logic [AW-1:0] im_waddr;
  logic [31:0]   im_wdata;
  logic          cpu_halt;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img [DEPTH];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  im_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .cpu_halt(cpu_halt), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  // Write monitor: every im_we cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && im_we) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL im_write: unexpected write addr=%0d data=%h, required no write", im_waddr, im_wdata);
      end else begin
        e = exp_q.pop_front();
        if (im_waddr !== e.addr || im_wdata !== e.data) begin
          errors++;
          $display("FAIL im_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   im_waddr, im_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 0);
    chk({tag, "_im_we"}, 32'(im_we), 0);
    chk({tag, "_im_waddr"}, 32'(im_waddr), 0);
    chk({tag, "_im_wdata"}, im_wdata, 0);
    chk({tag, "_cpu_halt"}, 32'(cpu_halt), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_words_loaded"}, 32'(words_loaded), 0);
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout: rx_ready=%0b, required 1 within 100 cycles", rx_ready);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // One complete load of img[0..n-1]; expected outcome derived from the stream rules.
  task automatic do_load(input int n, input bit gaps, input bit poke, input bit good_chk);
    logic [15:0] cnt;
    logic [7:0]  x;
    logic [31:0] w;
    bit          ok;
    bit          exp_done;
    int          t;
    cnt = 16'(n);
    ok  = (n >= 1) && (n <= int'(DEPTH));
    x   = 8'h00;
    pulse_start();
    chk("start_busy", 32'(busy), 1);
    chk("start_halt", 32'(cpu_halt), 1);
    chk("start_rx_ready", 32'(rx_ready), 1);
    chk("start_done", 32'(done | error), 0);
    send_byte(cnt[15:8], gaps);
    send_byte(cnt[7:0], gaps);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        w = img[i];
        exp_q.push_back('{addr: AW'(i), data: w});
        if (poke && i == 1) begin
          rx_valid   = 1'b0;
          load_start = 1'b1;
          @(negedge clk);
          load_start = 1'b0;
        end
        for (int b = 0; b < 4; b++) begin
          x = x ^ w[31-8*b -: 8];
          send_byte(w[31-8*b -: 8], gaps);
        end
      end
      if (CHK_EN) send_byte(good_chk ? x : (x ^ 8'h01), gaps);
    end
    rx_valid = 1'b0;
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    exp_done = ok && (good_chk || !CHK_EN);
    chk("end_busy", 32'(busy), 0);
    chk("end_done", 32'(done), 32'(exp_done));
    chk("end_error", 32'(error), 32'(!exp_done));
    chk("end_cpu_halt", 32'(cpu_halt), 32'(!exp_done));
    chk("end_words_loaded", 32'(words_loaded), ok ? 32'(n) : 0);
    chk("end_writes_pending", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    img[0] = 32'h20110001;
    img[1] = 32'h20120002;
    do_load(2, 1'b0, 1'b0, 1'b1);

    do_load(0, 1'b0, 1'b0, 1'b1);
    do_load(1025, 1'b0, 1'b0, 1'b1);
    do_load(65535, 1'b1, 1'b0, 1'b1);

    img[0] = 32'h0000000C;
    do_load(1, 1'b0, 1'b0, 1'b1);
    do_load(1, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      n = int'($urandom_range(3, 8));
      for (int i = 0; i < n; i++) img[i] = $urandom;
      do_load(n, 1'b1, 1'b1, 1'b1);
    end

    // Reset after six stream bytes (count + first word) while that word's write is on the bus.
    for (int i = 0; i < 3; i++) img[i] = $urandom;
    exp_q.push_back('{addr: AW'(0), data: img[0]});
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    for (int b = 0; b < 4; b++) send_byte(img[0][31-8*b -: 8], 1'b0);
    #2 rst = 1'b1;
    rx_valid = 1'b0;
    #1 chk_reset_outputs("midload_reset");
    chk("midload_writes_pending", 32'(exp_q.size()), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_load(3, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < int'(DEPTH); i++) img[i] = $urandom;
    do_load(int'(DEPTH), 1'b0, 1'b0, 1'b1);
    chk("full_last_waddr", 32'(im_waddr), DEPTH - 1);

    repeat (5) @(negedge clk);
    chk("final_writes_pending", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
